// File: rtl/sdram_ctrl_pkg.sv
// Definitions shared by the SDRAM CSR slave and the boot-time CSR loader.
// CSR map, init-done bit position, loader FSM states and error codes.
package sdram_ctrl_pkg;

  localparam int unsigned CSR_CTRL      = 'h0;
  localparam int unsigned CSR_TIME      = 'h4;
  localparam int unsigned CSR_TREF      = 'h8;
  localparam int unsigned INIT_DONE_BIT = 30;

  localparam logic [2:0] LOADER_PPROT = 3'b001;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARB,
    ST_POLL_S,
    ST_POLL_A,
    ST_WR_S,
    ST_WR_A,
    ST_VFY_S,
    ST_VFY_A,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_SLVERR  = 3'd1,
    ERR_TIMEOUT = 3'd2,
    ERR_POLL    = 3'd3,
    ERR_VERIFY  = 3'd4
  } loader_err_t;

  typedef enum logic {
    OWNER_HOST   = 1'b0,
    OWNER_LOADER = 1'b1
  } owner_t;

  // Write order: TIMING, TREF, CTRL (CTRL last so the controller starts fully configured).
  function automatic int unsigned step_addr(input logic [1:0] step);
    case (step)
      2'd0:    return CSR_TIME;
      2'd1:    return CSR_TREF;
      default: return CSR_CTRL;
    endcase
  endfunction

  function automatic logic [3:0] step_strb(input logic [1:0] step);
    return (step == 2'd1) ? 4'h3 : 4'hF;
  endfunction

endpackage

// File: rtl/sdram_apb_mux.sv
// Combinational 2:1 APB request mux and response steering between the host
// master and the loader, selected by the loader ownership flag.
module sdram_apb_mux #(
  parameter int PADDR_SIZE = 4,
  parameter int PDATA_SIZE = 32
) (
  input  logic                    loader_owns,
  input  logic                    s_PSEL,
  input  logic                    s_PENABLE,
  input  logic                    s_PWRITE,
  input  logic [PADDR_SIZE-1:0]   s_PADDR,
  input  logic [PDATA_SIZE-1:0]   s_PWDATA,
  input  logic [3:0]              s_PSTRB,
  input  logic [2:0]              s_PPROT,
  output logic [PDATA_SIZE-1:0]   s_PRDATA,
  output logic                    s_PREADY,
  output logic                    s_PSLVERR,
  input  logic                    loader_psel,
  input  logic                    loader_penable,
  input  logic                    loader_pwrite,
  input  logic [PADDR_SIZE-1:0]   loader_paddr,
  input  logic [PDATA_SIZE-1:0]   loader_pwdata,
  input  logic [3:0]              loader_pstrb,
  input  logic [2:0]              loader_pprot,
  output logic                    m_PSEL,
  output logic                    m_PENABLE,
  output logic                    m_PWRITE,
  output logic [PADDR_SIZE-1:0]   m_PADDR,
  output logic [PDATA_SIZE-1:0]   m_PWDATA,
  output logic [3:0]              m_PSTRB,
  output logic [2:0]              m_PPROT,
  input  logic [PDATA_SIZE-1:0]   m_PRDATA,
  input  logic                    m_PREADY,
  input  logic                    m_PSLVERR
);

  assign m_PSEL    = loader_owns ? loader_psel    : s_PSEL;
  assign m_PENABLE = loader_owns ? loader_penable : s_PENABLE;
  assign m_PWRITE  = loader_owns ? loader_pwrite  : s_PWRITE;
  assign m_PADDR   = loader_owns ? loader_paddr   : s_PADDR;
  assign m_PWDATA  = loader_owns ? loader_pwdata  : s_PWDATA;
  assign m_PSTRB   = loader_owns ? loader_pstrb   : s_PSTRB;
  assign m_PPROT   = loader_owns ? loader_pprot   : s_PPROT;

  // While the loader owns the slave, the host sees a wait state forever.
  assign s_PRDATA  = loader_owns ? '0   : m_PRDATA;
  assign s_PREADY  = loader_owns ? 1'b0 : m_PREADY;
  assign s_PSLVERR = loader_owns ? 1'b0 : m_PSLVERR;

endmodule

// File: rtl/sdram_csr_loader.sv
// Boot-time CSR sequencer (poll init_done, write TIMING/TREF/CTRL) with host
// APB passthrough. Optional readback check enabled by SDRAM_CSR_LOADER_VERIFY_EN.
module sdram_csr_loader
  import sdram_ctrl_pkg::*;
#(
  parameter int          PADDR_SIZE     = 4,
  parameter int          PDATA_SIZE     = 32,
  parameter logic [31:0] CTRL_VALUE     = 32'h0,
  parameter logic [31:0] TIMING_VALUE   = 32'h0,
  parameter logic [15:0] TREF_VALUE     = 16'd128,
  parameter bit          AUTO_START     = 1'b0,
  parameter int          MAX_POLL       = 4096,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                  PRESETn,
  input  logic                  PCLK,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [2:0]            err_code_o,
  input  logic                  s_PSEL,
  input  logic                  s_PENABLE,
  input  logic                  s_PWRITE,
  input  logic [PADDR_SIZE-1:0] s_PADDR,
  input  logic [PDATA_SIZE-1:0] s_PWDATA,
  input  logic [3:0]            s_PSTRB,
  input  logic [2:0]            s_PPROT,
  output logic [PDATA_SIZE-1:0] s_PRDATA,
  output logic                  s_PREADY,
  output logic                  s_PSLVERR,
  output logic                  m_PSEL,
  output logic                  m_PENABLE,
  output logic                  m_PWRITE,
  output logic [PADDR_SIZE-1:0] m_PADDR,
  output logic [PDATA_SIZE-1:0] m_PWDATA,
  output logic [3:0]            m_PSTRB,
  output logic [2:0]            m_PPROT,
  input  logic [PDATA_SIZE-1:0] m_PRDATA,
  input  logic                  m_PREADY,
  input  logic                  m_PSLVERR
);

  localparam int POLL_W = $clog2(MAX_POLL + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  function automatic logic [PDATA_SIZE-1:0] step_data(input logic [1:0] step);
    case (step)
      2'd0:    return PDATA_SIZE'(TIMING_VALUE);
      2'd1:    return PDATA_SIZE'(TREF_VALUE);
      default: return PDATA_SIZE'(CTRL_VALUE);
    endcase
  endfunction

  loader_state_t state_reg, state_next;
  owner_t        owner_reg, owner_next;
  loader_err_t   code_reg, code_next, fail_code;
  logic [1:0]        step_reg, step_next;
  logic [POLL_W-1:0] poll_reg, poll_next;
  logic [TO_W-1:0]   to_reg, to_next;
  logic busy_reg, busy_next, done_reg, done_next, err_reg, err_next;
  logic auto_reg, auto_next;
  logic fail, timed_out;

  logic                  psel_reg, psel_next, penable_reg, penable_next;
  logic                  pwrite_reg, pwrite_next;
  logic [PADDR_SIZE-1:0] paddr_reg, paddr_next;
  logic [PDATA_SIZE-1:0] pwdata_reg, pwdata_next;
  logic [3:0]            pstrb_reg, pstrb_next;
  logic [2:0]            pprot_reg, pprot_next;

  assign timed_out = !m_PREADY && (to_reg == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    code_next  = code_reg;
    step_next  = step_reg;
    poll_next  = poll_reg;
    to_next    = to_reg;
    busy_next  = busy_reg;
    done_next  = done_reg;
    err_next   = err_reg;
    auto_next  = auto_reg;
    fail       = 1'b0;
    fail_code  = ERR_NONE;
    unique case (state_reg)
      ST_IDLE: begin
        if (start_i || auto_reg) begin
          state_next = ST_ARB;
          auto_next  = 1'b0;
          done_next  = 1'b0;
          err_next   = 1'b0;
          code_next  = ERR_NONE;
        end
      end
      ST_ARB: begin
        // Never cut a host transfer short: wait for an idle host bus.
        if (!s_PSEL) begin
          state_next = ST_POLL_S;
          owner_next = OWNER_LOADER;
          busy_next  = 1'b1;
          poll_next  = '0;
        end
      end
      ST_POLL_S: begin
        state_next = ST_POLL_A;
        to_next    = '0;
      end
      ST_POLL_A: begin
        if (m_PREADY && m_PSLVERR) begin
          fail      = 1'b1;
          fail_code = ERR_SLVERR;
        end else if (m_PREADY) begin
          if (m_PRDATA[INIT_DONE_BIT]) begin
            state_next = ST_WR_S;
            step_next  = 2'd0;
          end else if (poll_reg == POLL_W'(MAX_POLL - 1)) begin
            fail      = 1'b1;
            fail_code = ERR_POLL;
          end else begin
            state_next = ST_POLL_S;
            poll_next  = poll_reg + POLL_W'(1);
          end
        end else if (timed_out) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end else begin
          to_next = to_reg + TO_W'(1);
        end
      end
      ST_WR_S: begin
        state_next = ST_WR_A;
        to_next    = '0;
      end
      ST_WR_A: begin
        if (m_PREADY && m_PSLVERR) begin
          fail      = 1'b1;
          fail_code = ERR_SLVERR;
        end else if (m_PREADY) begin
          if (step_reg == 2'd2) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
            owner_next = OWNER_HOST;
          end else begin
`ifdef SDRAM_CSR_LOADER_VERIFY_EN
            state_next = ST_VFY_S;
`else
            state_next = ST_WR_S;
            step_next  = step_reg + 2'd1;
`endif
          end
        end else if (timed_out) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end else begin
          to_next = to_reg + TO_W'(1);
        end
      end
`ifdef SDRAM_CSR_LOADER_VERIFY_EN
      ST_VFY_S: begin
        state_next = ST_VFY_A;
        to_next    = '0;
      end
      ST_VFY_A: begin
        if (m_PREADY && m_PSLVERR) begin
          fail      = 1'b1;
          fail_code = ERR_SLVERR;
        end else if (m_PREADY) begin
          // TREF is a 16-bit register; upper read bits are don't-care.
          if ((step_reg == 2'd0 && m_PRDATA != PDATA_SIZE'(TIMING_VALUE)) ||
              (step_reg == 2'd1 && m_PRDATA[15:0] != TREF_VALUE)) begin
            fail      = 1'b1;
            fail_code = ERR_VERIFY;
          end else begin
            state_next = ST_WR_S;
            step_next  = step_reg + 2'd1;
          end
        end else if (timed_out) begin
          fail      = 1'b1;
          fail_code = ERR_TIMEOUT;
        end else begin
          to_next = to_reg + TO_W'(1);
        end
      end
`endif
      ST_DONE, ST_ERR: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
      default: state_next = ST_IDLE;
    endcase
    if (fail) begin
      state_next = ST_ERR;
      err_next   = 1'b1;
      code_next  = fail_code;
      owner_next = OWNER_HOST;
    end
  end

  // Loader bus is decoded from the next state so m_* comes straight from flops.
  always_comb begin
    psel_next    = 1'b0;
    penable_next = 1'b0;
    pwrite_next  = 1'b0;
    paddr_next   = '0;
    pwdata_next  = '0;
    pstrb_next   = 4'h0;
    pprot_next   = 3'b000;
    unique case (state_next)
      ST_POLL_S, ST_POLL_A: begin
        psel_next    = 1'b1;
        penable_next = (state_next == ST_POLL_A);
        paddr_next   = PADDR_SIZE'(CSR_CTRL);
      end
      ST_WR_S, ST_WR_A: begin
        psel_next    = 1'b1;
        penable_next = (state_next == ST_WR_A);
        pwrite_next  = 1'b1;
        paddr_next   = PADDR_SIZE'(step_addr(step_next));
        pwdata_next  = step_data(step_next);
        pstrb_next   = step_strb(step_next);
      end
`ifdef SDRAM_CSR_LOADER_VERIFY_EN
      ST_VFY_S, ST_VFY_A: begin
        psel_next    = 1'b1;
        penable_next = (state_next == ST_VFY_A);
        paddr_next   = PADDR_SIZE'(step_addr(step_next));
      end
`endif
      default: ;
    endcase
    if (psel_next) pprot_next = LOADER_PPROT;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg   <= ST_IDLE;
      owner_reg   <= OWNER_HOST;
      code_reg    <= ERR_NONE;
      step_reg    <= 2'd0;
      poll_reg    <= '0;
      to_reg      <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      auto_reg    <= AUTO_START;
      psel_reg    <= 1'b0;
      penable_reg <= 1'b0;
      pwrite_reg  <= 1'b0;
      paddr_reg   <= '0;
      pwdata_reg  <= '0;
      pstrb_reg   <= 4'h0;
      pprot_reg   <= 3'b000;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      code_reg    <= code_next;
      step_reg    <= step_next;
      poll_reg    <= poll_next;
      to_reg      <= to_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      auto_reg    <= auto_next;
      psel_reg    <= psel_next;
      penable_reg <= penable_next;
      pwrite_reg  <= pwrite_next;
      paddr_reg   <= paddr_next;
      pwdata_reg  <= pwdata_next;
      pstrb_reg   <= pstrb_next;
      pprot_reg   <= pprot_next;
    end
  end

  assign busy_o     = busy_reg;
  assign done_o     = done_reg;
  assign err_o      = err_reg;
  assign err_code_o = code_reg;

  sdram_apb_mux #(
    .PADDR_SIZE(PADDR_SIZE),
    .PDATA_SIZE(PDATA_SIZE)
  ) apb_mux (
    .loader_owns   (owner_reg == OWNER_LOADER),
    .s_PSEL        (s_PSEL),
    .s_PENABLE     (s_PENABLE),
    .s_PWRITE      (s_PWRITE),
    .s_PADDR       (s_PADDR),
    .s_PWDATA      (s_PWDATA),
    .s_PSTRB       (s_PSTRB),
    .s_PPROT       (s_PPROT),
    .s_PRDATA      (s_PRDATA),
    .s_PREADY      (s_PREADY),
    .s_PSLVERR     (s_PSLVERR),
    .loader_psel   (psel_reg),
    .loader_penable(penable_reg),
    .loader_pwrite (pwrite_reg),
    .loader_paddr  (paddr_reg),
    .loader_pwdata (pwdata_reg),
    .loader_pstrb  (pstrb_reg),
    .loader_pprot  (pprot_reg),
    .m_PSEL        (m_PSEL),
    .m_PENABLE     (m_PENABLE),
    .m_PWRITE      (m_PWRITE),
    .m_PADDR       (m_PADDR),
    .m_PWDATA      (m_PWDATA),
    .m_PSTRB       (m_PSTRB),
    .m_PPROT       (m_PPROT),
    .m_PRDATA      (m_PRDATA),
    .m_PREADY      (m_PREADY),
    .m_PSLVERR     (m_PSLVERR)
  );

endmodule
